// File: rtl/membridge_pkg.sv
// membridge_pkg: command codes and bank FSM state encoding
// shared by the bank machine and its request FIFO.
package membridge_pkg;

   localparam logic [1:0] CMD_PRE = 2'b00;
   localparam logic [1:0] CMD_ACT = 2'b01;
   localparam logic [1:0] CMD_RD  = 2'b10;
   localparam logic [1:0] CMD_WR  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_WAIT_TRP,
      ST_ACT,
      ST_WAIT_TRCD,
      ST_RW,
      ST_REF_HOLD
   } bank_state_t;

   // States in which a command is presented to the scheduler.
   function automatic logic is_cmd_state(input bank_state_t s);
      return (s == ST_PRE) || (s == ST_ACT) || (s == ST_RW);
   endfunction

endpackage

// File: rtl/bank_req_fifo.sv
// bank_req_fifo: synchronous request FIFO holding {we,row,col}.
// Ports: i_clk/i_rst (async high), i_push/i_data in, i_pop in,
//  o_head (oldest), o_peek (head+1), o_count, o_full, o_empty.
module bank_req_fifo
   import membridge_pkg::*;
#(
   parameter int W     = 25,
   parameter int DEPTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_push,
   input  logic [W-1:0]           i_data,
   input  logic                   i_pop,
   output logic [W-1:0]           o_head,
   output logic [W-1:0]           o_peek,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_full,
   output logic                   o_empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic          w_push;
   logic          w_pop;
   logic [PW-1:0] w_peek_ptr;

   // Full blocks pushes even when a pop happens the same cycle.
   assign o_full     = (r_count == CW'(DEPTH));
   assign o_empty    = (r_count == '0);
   assign w_push     = i_push && !o_full;
   assign w_pop      = i_pop && !o_empty;
   assign w_peek_ptr = r_rd_ptr + PW'(1);
   assign o_head     = r_mem[r_rd_ptr];
   assign o_peek     = r_mem[w_peek_ptr];
   assign o_count    = r_count;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: pointers define validity.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/bank_machine.sv
// bank_machine: per-bank request engine; queues requests, tracks the
// open row and issues PRE/ACT/RD/WR with tRP/tRCD spacing.
// Ports: sys_clk, sys_rst (async high); req_* request in (ready=!full);
//  cmd_* valid/ready command out; ref_req/ref_ack refresh handshake;
//  row_open/open_row current bank row status.
module bank_machine
   import membridge_pkg::*;
#(
   parameter int ROW_BITS = 14,
   parameter int COL_BITS = 10,
   parameter int DEPTH    = 4,
   parameter int TRP      = 3,
   parameter int TRCD     = 3
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ROW_BITS-1:0] req_row,
   input  logic [COL_BITS-1:0] req_col,
   output logic                cmd_valid,
   input  logic                cmd_ready,
   output logic [1:0]          cmd_type,
   output logic [ROW_BITS-1:0] cmd_row,
   output logic [COL_BITS-1:0] cmd_col,
   input  logic                ref_req,
   output logic                ref_ack,
   output logic                row_open,
   output logic [ROW_BITS-1:0] open_row
);

   localparam int EW   = 1 + ROW_BITS + COL_BITS;
   localparam int CW   = $clog2(DEPTH) + 1;
   localparam int TMAX = (TRP > TRCD) ? TRP : TRCD;
   localparam int TW   = $clog2(TMAX);

   bank_state_t         r_state;
   bank_state_t         w_next;
   logic [TW-1:0]       r_timer;
   logic                r_row_open;
   logic [ROW_BITS-1:0] r_open_row;
   logic [1:0]          r_cmd_type;
   logic [ROW_BITS-1:0] r_cmd_row;
   logic [COL_BITS-1:0] r_cmd_col;

   logic [EW-1:0]       w_head;
   logic [EW-1:0]       w_peek;
   logic [CW-1:0]       w_count;
   logic                w_full;
   logic                w_empty;
   logic                w_pop;

   logic                w_head_we;
   logic [ROW_BITS-1:0] w_head_row;
   logic [COL_BITS-1:0] w_head_col;
   logic                w_peek_we;
   logic [ROW_BITS-1:0] w_peek_row;
   logic [COL_BITS-1:0] w_peek_col;
   logic                w_head_hit;
   logic                w_peek_hit;
   logic                w_peek_ok;

   logic                w_load;
   logic                w_src_we;
   logic [1:0]          w_ld_type;
   logic [ROW_BITS-1:0] w_ld_row;
   logic [COL_BITS-1:0] w_ld_col;

   bank_req_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (sys_clk),
      .i_rst   (sys_rst),
      .i_push  (req_valid),
      .i_data  ({req_we, req_row, req_col}),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_peek  (w_peek),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_head_we  = w_head[EW-1];
   assign w_head_row = w_head[COL_BITS +: ROW_BITS];
   assign w_head_col = w_head[COL_BITS-1:0];
   assign w_peek_we  = w_peek[EW-1];
   assign w_peek_row = w_peek[COL_BITS +: ROW_BITS];
   assign w_peek_col = w_peek[COL_BITS-1:0];
   assign w_head_hit = (w_head_row == r_open_row);
   assign w_peek_hit = (w_peek_row == r_open_row);
   assign w_peek_ok  = (w_count > CW'(1));

   assign req_ready  = !w_full;
   assign cmd_valid  = is_cmd_state(r_state);
   assign cmd_type   = r_cmd_type;
   assign cmd_row    = r_cmd_row;
   assign cmd_col    = r_cmd_col;
   assign ref_ack    = (r_state == ST_REF_HOLD) && ref_req;
   assign row_open   = r_row_open;
   assign open_row   = r_open_row;

   always_comb begin
      w_next = r_state;
      w_pop  = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (ref_req && r_row_open) begin
               w_next = ST_PRE;
            end else if (ref_req && r_timer == '0) begin
               w_next = ST_REF_HOLD;
            end else if (!w_empty) begin
               if (r_row_open)
                  w_next = w_head_hit ? ST_RW : ST_PRE;
               else if (r_timer == '0)
                  w_next = ST_ACT;
            end
         end
         ST_PRE: begin
            if (cmd_ready) w_next = ST_WAIT_TRP;
         end
         ST_WAIT_TRP: begin
            // Leave as the count reaches zero so ACT appears TRP
            // cycles after the PRE handshake.
            if (r_timer == TW'(1)) begin
               if (ref_req)       w_next = ST_REF_HOLD;
               else if (!w_empty) w_next = ST_ACT;
               else               w_next = ST_IDLE;
            end
         end
         ST_ACT: begin
            if (cmd_ready) w_next = ST_WAIT_TRCD;
         end
         ST_WAIT_TRCD: begin
            if (r_timer == TW'(1)) w_next = ST_RW;
         end
         ST_RW: begin
            if (cmd_ready) begin
               w_pop = 1'b1;
               if (w_peek_ok && w_peek_hit && !ref_req)
                  w_next = ST_RW;
               else
                  w_next = ST_IDLE;
            end
         end
         ST_REF_HOLD: begin
            if (!ref_req) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Command fields are captured on entry to a command state so they
   // hold steady until accepted, even if the FIFO head slot is written.
   // The only command-to-command path is RW->RW, which uses the peek.
   always_comb begin
      w_load    = is_cmd_state(w_next) &&
                  (!is_cmd_state(r_state) || cmd_ready);
      w_src_we  = (r_state == ST_RW) ? w_peek_we  : w_head_we;
      w_ld_row  = (r_state == ST_RW) ? w_peek_row : w_head_row;
      w_ld_col  = (r_state == ST_RW) ? w_peek_col : w_head_col;
      w_ld_type = CMD_PRE;
      if (w_next == ST_ACT)
         w_ld_type = CMD_ACT;
      else if (w_next == ST_RW)
         w_ld_type = w_src_we ? CMD_WR : CMD_RD;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state    <= ST_IDLE;
         r_timer    <= '0;
         r_row_open <= 1'b0;
         r_open_row <= '0;
         r_cmd_type <= CMD_PRE;
         r_cmd_row  <= '0;
         r_cmd_col  <= '0;
      end else begin
         r_state <= w_next;
         if (w_load) begin
            r_cmd_type <= w_ld_type;
            r_cmd_row  <= w_ld_row;
            r_cmd_col  <= w_ld_col;
         end
         if (r_state == ST_PRE && cmd_ready) begin
            r_row_open <= 1'b0;
            r_timer    <= TW'(TRP - 1);
         end else if (r_state == ST_ACT && cmd_ready) begin
            r_row_open <= 1'b1;
            r_open_row <= r_cmd_row;
            r_timer    <= TW'(TRCD - 1);
         end else if ((r_state == ST_WAIT_TRP ||
                       r_state == ST_WAIT_TRCD) &&
                      r_timer != '0) begin
            r_timer <= r_timer - TW'(1);
         end
      end
   end

endmodule
